// File: rtl/bus_stream_scheduler_pkg.sv
// rtl/bus_stream_scheduler_pkg.sv - frame constants, FSM states and byte ordering for the IQ bus stream
package bus_stream_pkg;

  localparam int FRAME_BYTES = 8;
  localparam int TX_BYTES    = 4;
  localparam int SAMPLE_W    = 16;
  localparam int OVR_CNT_W   = 8;
  localparam int IDX_W       = 4;
  localparam int SNAP_W      = 4 * SAMPLE_W;

  localparam int TX_Q_HI = 0;
  localparam int TX_Q_LO = 1;
  localparam int TX_I_HI = 2;
  localparam int TX_I_LO = 3;

  typedef enum logic [1:0] {IDLE, XFER, COMMIT} state_t;

  // Snapshot is packed {VOICE_I, VOICE_Q, SPEC_I, SPEC_Q}; entry k is the bit offset of out byte k.
  localparam int OUT_SHIFT [FRAME_BYTES] = '{56, 48, 40, 32, 24, 16, 8, 0};

  function automatic logic [7:0] out_byte(input logic [SNAP_W-1:0] snap, input logic [2:0] k);
    return snap[OUT_SHIFT[k] +: 8];
  endfunction

  function automatic logic [7:0] frame_xor(input logic [SNAP_W-1:0] snap);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < FRAME_BYTES; i++) x = x ^ snap[8*i +: 8];
    return x;
  endfunction

  // TX shadow shifts bytes in from the right, so capture order k sits at the top after four strobes.
  function automatic logic [7:0] tx_byte(input logic [8*TX_BYTES-1:0] sh, input int k);
    return sh[8*(TX_BYTES-1-k) +: 8];
  endfunction

endpackage

// File: rtl/bus_stream_scheduler_if.sv
// rtl/bus_stream_scheduler_if.sv - bus stream pins and DDC/TX sample ports of the scheduler
interface bus_stream_scheduler_if;
  import bus_stream_pkg::*;

  logic                       iq_clock;
  logic                       bus_stream_in_valid;
  logic [7:0]                 bus_stream_data_in;
  logic signed [SAMPLE_W-1:0] VOICE_I;
  logic signed [SAMPLE_W-1:0] VOICE_Q;
  logic signed [SAMPLE_W-1:0] SPEC_I;
  logic signed [SAMPLE_W-1:0] SPEC_Q;
  logic [7:0]                 bus_stream_data_out;
  logic signed [SAMPLE_W-1:0] TX_I;
  logic signed [SAMPLE_W-1:0] TX_Q;
  logic                       tx_valid;
  logic                       frame_active;
  logic [OVR_CNT_W-1:0]       overrun_count;
  logic                       checksum_err;

  modport master (
    output iq_clock, bus_stream_in_valid, bus_stream_data_in, VOICE_I, VOICE_Q, SPEC_I, SPEC_Q,
    input  bus_stream_data_out, TX_I, TX_Q, tx_valid, frame_active, overrun_count, checksum_err
  );

  modport slave (
    input  iq_clock, bus_stream_in_valid, bus_stream_data_in, VOICE_I, VOICE_Q, SPEC_I, SPEC_Q,
    output bus_stream_data_out, TX_I, TX_Q, tx_valid, frame_active, overrun_count, checksum_err
  );

endinterface

// File: rtl/bus_stream_scheduler_sync.sv
// rtl/bus_stream_scheduler_sync.sv - 2-FF synchroniser with registered rising-edge pulse
module stream_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    meta_d  = async_in;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bus_stream_scheduler.sv
// rtl/bus_stream_scheduler.sv - IQ bus stream frame sequencer; BUS_STREAM_CHECKSUM_EN adds a 9th XOR byte
module bus_stream_scheduler
  import bus_stream_pkg::*;
(
  input logic                   clk_in,
  input logic                   reset_in,
  bus_stream_scheduler_if.slave bus
);

  logic iq_pulse;
  logic strobe;

  stream_edge_sync u_iq_sync  (.clk(clk_in), .rst(reset_in), .async_in(bus.iq_clock),            .pulse(iq_pulse));
  stream_edge_sync u_stb_sync (.clk(clk_in), .rst(reset_in), .async_in(bus.bus_stream_in_valid), .pulse(strobe));

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SNAP_W-1:0]       snap_q, snap_d;
  logic [8*TX_BYTES-1:0]   tx_sh_q, tx_sh_d;
  logic [7:0]              data_out_q, data_out_d;
  logic [SAMPLE_W-1:0]     tx_i_q, tx_i_d, tx_q_q, tx_q_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    frame_active_q, frame_active_d;
  logic [OVR_CNT_W-1:0]    ovr_q, ovr_d;
  logic [SNAP_W-1:0]       live_snap;
`ifdef BUS_STREAM_CHECKSUM_EN
  logic                    cksum_err_q, cksum_err_d;
`endif

  assign live_snap = {bus.VOICE_I, bus.VOICE_Q, bus.SPEC_I, bus.SPEC_Q};

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    snap_d         = snap_q;
    tx_sh_d        = tx_sh_q;
    data_out_d     = data_out_q;
    tx_i_d         = tx_i_q;
    tx_q_d         = tx_q_q;
    tx_valid_d     = 1'b0;
    frame_active_d = frame_active_q;
    ovr_d          = ovr_q;
`ifdef BUS_STREAM_CHECKSUM_EN
    cksum_err_d    = cksum_err_q;
`endif
    unique case (state_q)
      IDLE: begin
      end
      XFER: begin
        if (!iq_pulse && strobe) begin
          if (idx_q < IDX_W'(TX_BYTES)) tx_sh_d = {tx_sh_q[8*TX_BYTES-9:0], bus.bus_stream_data_in};
          idx_d = idx_q + 1'b1;
          if (idx_q < IDX_W'(FRAME_BYTES - 1)) begin
            data_out_d = out_byte(snap_q, idx_d[2:0]);
`ifdef BUS_STREAM_CHECKSUM_EN
          end else if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
            data_out_d = frame_xor(snap_q);
          end else begin
            frame_active_d = 1'b0;
            if (bus.bus_stream_data_in == (tx_byte(tx_sh_q, 0) ^ tx_byte(tx_sh_q, 1) ^
                                           tx_byte(tx_sh_q, 2) ^ tx_byte(tx_sh_q, 3))) begin
              state_d = COMMIT;
            end else begin
              state_d     = IDLE;
              cksum_err_d = 1'b1;
            end
          end
`else
          end else begin
            state_d        = COMMIT;
            frame_active_d = 1'b0;
          end
`endif
        end
      end
      COMMIT: begin
        tx_q_d     = {tx_byte(tx_sh_q, TX_Q_HI), tx_byte(tx_sh_q, TX_Q_LO)};
        tx_i_d     = {tx_byte(tx_sh_q, TX_I_HI), tx_byte(tx_sh_q, TX_I_LO)};
        tx_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A frame tick beats any strobe; during COMMIT the commit above still lands in the same edge.
    if (iq_pulse) begin
      if (state_q == XFER && ovr_q != '1) ovr_d = ovr_q + 1'b1;
      state_d        = XFER;
      idx_d          = '0;
      snap_d         = live_snap;
      tx_sh_d        = '0;
      data_out_d     = out_byte(live_snap, 3'd0);
      frame_active_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      snap_q         <= '0;
      tx_sh_q        <= '0;
      data_out_q     <= '0;
      tx_i_q         <= '0;
      tx_q_q         <= '0;
      tx_valid_q     <= 1'b0;
      frame_active_q <= 1'b0;
      ovr_q          <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      snap_q         <= snap_d;
      tx_sh_q        <= tx_sh_d;
      data_out_q     <= data_out_d;
      tx_i_q         <= tx_i_d;
      tx_q_q         <= tx_q_d;
      tx_valid_q     <= tx_valid_d;
      frame_active_q <= frame_active_d;
      ovr_q          <= ovr_d;
    end
  end

`ifdef BUS_STREAM_CHECKSUM_EN
  always_ff @(posedge clk_in) begin
    if (reset_in) cksum_err_q <= 1'b0;
    else          cksum_err_q <= cksum_err_d;
  end
  assign bus.checksum_err = cksum_err_q;
`else
  assign bus.checksum_err = 1'b0;
`endif

  assign bus.bus_stream_data_out = data_out_q;
  assign bus.TX_I                = tx_i_q;
  assign bus.TX_Q                = tx_q_q;
  assign bus.tx_valid            = tx_valid_q;
  assign bus.frame_active        = frame_active_q;
  assign bus.overrun_count       = ovr_q;

endmodule

// File: tb/tb_bus_stream_scheduler.sv
// tb/tb_bus_stream_scheduler.sv - directed and randomized checks of the bus stream scheduler
module tb_bus_stream_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_stream_scheduler_if bus_if ();

  bus_stream_scheduler dut (.clk_in(clk), .reset_in(rst), .bus(bus_if));

  int checks = 0;
  int failures = 0;
  int tx_highs = 0;

  logic [7:0]  exp_bytes [8];
  logic [15:0] exp_tx_i, exp_tx_q;
  logic [7:0]  exp_last;
  logic        exp_cerr;
  int          exp_ovr, exp_highs;
  bit          active;

  always @(posedge clk) if (bus_if.tx_valid === 1'b1) tx_highs++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] d);
    bus_if.bus_stream_data_in  = d;
    bus_if.bus_stream_in_valid = 1'b1;
    tick(4);
    bus_if.bus_stream_in_valid = 1'b0;
    tick(4);
  endtask

  task automatic iq_edge();
    bus_if.iq_clock = 1'b1;
    tick(4);
    bus_if.iq_clock = 1'b0;
    tick(4);
  endtask

  // Strobe whose edge puts the frame into COMMIT while an iq edge lands one cycle later.
  task automatic final_strobe(input logic [7:0] d, input bit with_iq);
    if (!with_iq) strobe(d);
    else begin
      bus_if.bus_stream_data_in  = d;
      bus_if.bus_stream_in_valid = 1'b1;
      tick(1);
      bus_if.iq_clock = 1'b1;
      tick(3);
      bus_if.bus_stream_in_valid = 1'b0;
      tick(1);
      bus_if.iq_clock = 1'b0;
      tick(4);
    end
  endtask

  task automatic rand_samples();
    bus_if.VOICE_I = 16'($urandom);
    bus_if.VOICE_Q = 16'($urandom);
    bus_if.SPEC_I  = 16'($urandom);
    bus_if.SPEC_Q  = 16'($urandom);
  endtask

  task automatic take_snapshot();
    exp_bytes[0] = bus_if.VOICE_I[15:8];
    exp_bytes[1] = bus_if.VOICE_I[7:0];
    exp_bytes[2] = bus_if.VOICE_Q[15:8];
    exp_bytes[3] = bus_if.VOICE_Q[7:0];
    exp_bytes[4] = bus_if.SPEC_I[15:8];
    exp_bytes[5] = bus_if.SPEC_I[7:0];
    exp_bytes[6] = bus_if.SPEC_Q[15:8];
    exp_bytes[7] = bus_if.SPEC_Q[7:0];
  endtask

  task automatic model_tick();
    if (active && exp_ovr < 255) exp_ovr++;
    take_snapshot();
    active = 1'b1;
  endtask

  task automatic begin_frame(input string tag);
    model_tick();
    iq_edge();
    chk({tag, "_byte0"}, {24'h0, bus_if.bus_stream_data_out}, {24'h0, exp_bytes[0]});
    chk({tag, "_active"}, {31'h0, bus_if.frame_active}, 32'd1);
    chk({tag, "_ovr"}, {24'h0, bus_if.overrun_count}, exp_ovr);
  endtask

  task automatic partial(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      strobe(8'($urandom));
      chk($sformatf("%s_b%0d", tag, k + 1), {24'h0, bus_if.bus_stream_data_out}, {24'h0, exp_bytes[k+1]});
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_dout"}, {24'h0, bus_if.bus_stream_data_out}, {24'h0, exp_last});
    chk({tag, "_active"}, {31'h0, bus_if.frame_active}, {31'h0, active});
    chk({tag, "_tx_i"}, {16'h0, bus_if.TX_I}, {16'h0, exp_tx_i});
    chk({tag, "_tx_q"}, {16'h0, bus_if.TX_Q}, {16'h0, exp_tx_q});
    chk({tag, "_txv_cycles"}, tx_highs, exp_highs);
    chk({tag, "_ovr"}, {24'h0, bus_if.overrun_count}, exp_ovr);
    chk({tag, "_cerr"}, {31'h0, bus_if.checksum_err}, {31'h0, exp_cerr});
  endtask

  task automatic run_frame(input string tag, input logic [31:0] tx_word, input bit with_iq, input bit bad);
    logic [7:0] d;
    logic [7:0] txx;
    logic [7:0] fx;
    txx = tx_word[31:24] ^ tx_word[23:16] ^ tx_word[15:8] ^ tx_word[7:0];
    fx = '0;
    for (int k = 0; k < 8; k++) fx = fx ^ exp_bytes[k];
`ifdef BUS_STREAM_CHECKSUM_EN
    for (int k = 0; k < 8; k++) begin
      d = (k < 4) ? tx_word[31-8*k -: 8] : 8'h00;
      strobe(d);
      if (k < 7) chk($sformatf("%s_b%0d", tag, k + 1), {24'h0, bus_if.bus_stream_data_out}, {24'h0, exp_bytes[k+1]});
      else       chk({tag, "_xor"}, {24'h0, bus_if.bus_stream_data_out}, {24'h0, fx});
    end
    if (with_iq) rand_samples();
    final_strobe(bad ? 8'h00 : txx, with_iq);
    if (bad) exp_cerr = 1'b1;
    else begin
      exp_tx_q = tx_word[31:16];
      exp_tx_i = tx_word[15:0];
      exp_highs++;
    end
    exp_last = fx;
`else
    for (int k = 0; k < 7; k++) begin
      d = (k < 4) ? tx_word[31-8*k -: 8] : 8'h00;
      strobe(d);
      chk($sformatf("%s_b%0d", tag, k + 1), {24'h0, bus_if.bus_stream_data_out}, {24'h0, exp_bytes[k+1]});
    end
    if (with_iq) rand_samples();
    final_strobe(bad ? fx : txx, with_iq);
    exp_tx_q = tx_word[31:16];
    exp_tx_i = tx_word[15:0];
    exp_highs++;
    exp_last = exp_bytes[7];
`endif
    active = 1'b0;
    if (with_iq) begin
      take_snapshot();
      active   = 1'b1;
      exp_last = exp_bytes[0];
    end
    chk_outputs(tag);
  endtask

  initial begin
    logic [15:0] hold_i, hold_q;
    bus_if.iq_clock            = 1'b0;
    bus_if.bus_stream_in_valid = 1'b0;
    bus_if.bus_stream_data_in  = 8'h00;
    bus_if.VOICE_I = '0;
    bus_if.VOICE_Q = '0;
    bus_if.SPEC_I  = '0;
    bus_if.SPEC_Q  = '0;
    exp_tx_i = '0; exp_tx_q = '0; exp_last = '0; exp_cerr = 1'b0;
    exp_ovr = 0; exp_highs = 0; active = 1'b0;
    rst = 1'b1;
    tick(3);
    chk_outputs("reset");
    chk("reset_txv", {31'h0, bus_if.tx_valid}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Directed frame with known samples and TX bytes.
    bus_if.VOICE_I = 16'h1234;
    bus_if.VOICE_Q = 16'h5678;
    bus_if.SPEC_I  = 16'h9ABC;
    bus_if.SPEC_Q  = 16'hDEF0;
    begin_frame("t1");
    chk("t1_first_byte", {24'h0, bus_if.bus_stream_data_out}, 32'h12);
    run_frame("t1", 32'hA1A2A3A4, 1'b0, 1'b0);
    chk("t1_tx_q_lit", {16'h0, bus_if.TX_Q}, 32'hA1A2);
    chk("t1_tx_i_lit", {16'h0, bus_if.TX_I}, 32'hA3A4);

    for (int f = 0; f < 4; f++) begin
      rand_samples();
      begin_frame($sformatf("rnd%0d", f));
      run_frame($sformatf("rnd%0d", f), $urandom, 1'b0, 1'b0);
    end

    // Abort after 5 strobes: TX must stay put and no commit pulse.
    rand_samples();
    begin_frame("t2_start");
    partial("t2", 5);
    hold_i = exp_tx_i;
    hold_q = exp_tx_q;
    rand_samples();
    begin_frame("t2_abort");
    chk("t2_ovr_one", {24'h0, bus_if.overrun_count}, 32'd1);
    chk("t2_tx_i_hold", {16'h0, bus_if.TX_I}, {16'h0, hold_i});
    chk("t2_tx_q_hold", {16'h0, bus_if.TX_Q}, {16'h0, hold_q});
    chk("t2_txv_cycles", tx_highs, exp_highs);

    // Live input changes after the snapshot must not leak out.
    bus_if.VOICE_I = ~bus_if.VOICE_I;
    bus_if.SPEC_Q  = ~bus_if.SPEC_Q;
    run_frame("t3", $urandom, 1'b0, 1'b0);

    // iq edge and strobe together: the strobe is dropped and the frame restarts at byte 0.
    rand_samples();
    begin_frame("both_start");
    partial("both_pre", 2);
    rand_samples();
    model_tick();
    bus_if.bus_stream_data_in  = 8'h5A;
    bus_if.bus_stream_in_valid = 1'b1;
    bus_if.iq_clock            = 1'b1;
    tick(4);
    bus_if.bus_stream_in_valid = 1'b0;
    bus_if.iq_clock            = 1'b0;
    tick(4);
    chk("both_byte0", {24'h0, bus_if.bus_stream_data_out}, {24'h0, exp_bytes[0]});
    chk("both_ovr", {24'h0, bus_if.overrun_count}, exp_ovr);
    run_frame("both_after", $urandom, 1'b0, 1'b0);

    // iq edge while in COMMIT: commit completes, next frame starts, no overrun.
    rand_samples();
    begin_frame("cmt_start");
    run_frame("cmt_iq", $urandom, 1'b1, 1'b0);
    run_frame("cmt_next", $urandom, 1'b0, 1'b0);

    // Saturating overrun counter.
    rand_samples();
    begin_frame("sat_start");
    for (int i = 0; i < 300; i++) begin
      bus_if.VOICE_I = 16'($urandom);
      model_tick();
      iq_edge();
    end
    chk("sat_ovr", {24'h0, bus_if.overrun_count}, 32'd255);
    chk("sat_model", {24'h0, bus_if.overrun_count}, exp_ovr);
    run_frame("sat_done", $urandom, 1'b0, 1'b0);

    // Reset in the middle of a frame at idx 3.
    rand_samples();
    begin_frame("rst_start");
    partial("rst_pre", 3);
    rst = 1'b1;
    tick(1);
    exp_tx_i = '0; exp_tx_q = '0; exp_last = '0; exp_cerr = 1'b0;
    exp_ovr = 0; active = 1'b0;
    chk_outputs("rst_mid");
    chk("rst_txv", {31'h0, bus_if.tx_valid}, 32'd0);
    rst = 1'b0;
    tick(2);
    rand_samples();
    begin_frame("rst_after");
    run_frame("rst_after", $urandom, 1'b0, 1'b0);

`ifdef BUS_STREAM_CHECKSUM_EN
    bus_if.VOICE_I = 16'h1234;
    bus_if.VOICE_Q = 16'h5678;
    bus_if.SPEC_I  = 16'h9ABC;
    bus_if.SPEC_Q  = 16'hDEF0;
    begin_frame("ck_good");
    run_frame("ck_good", 32'hA1A2A3A4, 1'b0, 1'b0);
    begin_frame("ck_bad");
    run_frame("ck_bad", 32'h0BADCAFE, 1'b0, 1'b1);
    chk("ck_bad_sticky", {31'h0, bus_if.checksum_err}, 32'd1);
    rand_samples();
    begin_frame("ck_later");
    run_frame("ck_later", $urandom, 1'b0, 1'b0);
`else
    // A stray 9th strobe after a completed frame lands in IDLE and is ignored.
    strobe(8'hA4);
    chk_outputs("idle_strobe");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
